game_scoreboard: RTL and testbench

- Downstream consumer of the counter game block. Takes its single-cycle WINNER/LOSER pulses, the GAMEOVER flag, WHO and the live counter value.
- Tallies rounds per side and declares a match winner after MATCH_ROUNDS rounds.
- Queues timestamped-free event records into a small FIFO, drained over a valid/ready interface by the display/logging stage.

---
 rtl/game_scoreboard.sv | 235 +++++++++++++++++++++++
 tb/tb_game_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_scoreboard.sv
// game_scoreboard: match tally and event queue for the counter game block.
//
// Counts rounds per side from GAMEOVER rising edges, declares a match winner
// once a side reaches MATCH_ROUNDS, and queues event records into a small
// first-word-fall-through FIFO drained over a valid/ready handshake.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   WINNER, LOSER           one-cycle pulses from the game block
//   GAMEOVER, WHO           round-end flag and round result (10 win, 01 lose)
//   counter_value           payload for WIN/LOSE events
//   clear                   synchronous match restart (FIFO kept)
//   evt_valid/evt_ready     FIFO head handshake
//   evt_code, evt_data      FIFO head record (held after the FIFO empties)
//   evt_time                push-cycle timestamp (optional, see below)
//   win_rounds, lose_rounds round tallies, saturating at 15
//   match_over, match_winner match decided and WHO value of the victor
//   overflow                sticky: an event was lost
//
// Optional feature: define SCOREBOARD_TIMESTAMP_EN to add a 16-bit free-running
// cycle counter, store it with every FIFO entry and expose it on evt_time.
module game_scoreboard #(
    parameter int unsigned COUNTER_SIZE = 4,
    parameter int unsigned MATCH_ROUNDS = 3,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    WINNER,
    input  logic                    LOSER,
    input  logic                    GAMEOVER,
    input  logic [1:0]              WHO,
    input  logic [COUNTER_SIZE-1:0] counter_value,
    input  logic                    clear,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [2:0]              evt_code,
    output logic [COUNTER_SIZE-1:0] evt_data,
`ifdef SCOREBOARD_TIMESTAMP_EN
    output logic [15:0]             evt_time,
`endif
    output logic [3:0]              win_rounds,
    output logic [3:0]              lose_rounds,
    output logic                    match_over,
    output logic [1:0]              match_winner,
    output logic                    overflow
);
    localparam int unsigned AW           = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT   = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  MATCH_TARGET = 4'(MATCH_ROUNDS);
    localparam logic [2:0]  CODE_WIN     = 3'd1;
    localparam logic [2:0]  CODE_LOSE    = 3'd2;
    localparam logic [2:0]  CODE_ROUND_W = 3'd3;
    localparam logic [2:0]  CODE_ROUND_L = 3'd4;
    localparam logic [2:0]  CODE_MATCH   = 3'd5;

    typedef enum logic {StPlay, StMatchEnd} state_t;

    state_t                  state_q;
    logic                    gameover_q;
    logic                    pend_round_q;
    logic [2:0]              pend_round_code_q;
    logic [COUNTER_SIZE-1:0] pend_round_data_q;
    logic                    pend_match_q;

    logic [2:0]              code_mem [FIFO_DEPTH];
    logic [COUNTER_SIZE-1:0] data_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q;
    logic [2:0]              last_code_q;
    logic [COUNTER_SIZE-1:0] last_data_q;
`ifdef SCOREBOARD_TIMESTAMP_EN
    logic [15:0]             time_q;
    logic [15:0]             time_mem [FIFO_DEPTH];
    logic [15:0]             last_time_q;
`endif

    // Input events are only honoured in play and never alongside clear.
    logic       accepting, pulse_evt, round_rise, round_w, round_l, match_hit;
    logic [3:0] win_inc, lose_inc;

    assign accepting  = (state_q == StPlay) && !clear;
    assign pulse_evt  = accepting && (WINNER || LOSER);
    assign round_rise = accepting && GAMEOVER && !gameover_q;
    assign round_w    = round_rise && (WHO == 2'b10);
    assign round_l    = round_rise && (WHO == 2'b01);
    assign win_inc    = (win_rounds == 4'hF) ? 4'hF : win_rounds + 4'd1;
    assign lose_inc   = (lose_rounds == 4'hF) ? 4'hF : lose_rounds + 4'd1;
    assign match_hit  = (round_w && (win_inc == MATCH_TARGET)) ||
                        (round_l && (lose_inc == MATCH_TARGET));

    // Push arbitration: pulse > pending round > pending match. A pending event
    // selected here is consumed whether or not the FIFO has room.
    logic                    push_req, take_round, take_match;
    logic [2:0]              push_code;
    logic [COUNTER_SIZE-1:0] push_data;

    always_comb begin
        push_req   = 1'b0;
        take_round = 1'b0;
        take_match = 1'b0;
        push_code  = 3'd0;
        push_data  = '0;
        if (pulse_evt) begin
            push_req  = 1'b1;
            push_code = LOSER ? CODE_LOSE : CODE_WIN;
            push_data = counter_value;
        end else if (!clear && pend_round_q) begin
            push_req   = 1'b1;
            take_round = 1'b1;
            push_code  = pend_round_code_q;
            push_data  = pend_round_data_q;
        end else if (!clear && pend_match_q) begin
            push_req   = 1'b1;
            take_match = 1'b1;
            push_code  = CODE_MATCH;
            push_data  = COUNTER_SIZE'(match_winner);
        end
    end

    logic pop, push_ok, drop, collision;

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = push_req && ((count_q != FULL_COUNT) || pop);
    assign drop      = push_req && !push_ok;
    // A new round result while the previous one is still waiting overwrites it.
    assign collision = (round_w || round_l) && pend_round_q && !take_round;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StPlay;
            win_rounds   <= 4'd0;
            lose_rounds  <= 4'd0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
        end else if (clear) begin
            state_q      <= StPlay;
            win_rounds   <= 4'd0;
            lose_rounds  <= 4'd0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            if (round_w) win_rounds <= win_inc;
            if (round_l) lose_rounds <= lose_inc;
            if (match_hit) begin
                state_q      <= StMatchEnd;
                match_over   <= 1'b1;
                match_winner <= WHO;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gameover_q        <= 1'b0;
            pend_round_q      <= 1'b0;
            pend_round_code_q <= 3'd0;
            pend_round_data_q <= '0;
            pend_match_q      <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            gameover_q <= GAMEOVER;
            if (clear) begin
                pend_round_q <= 1'b0;
                pend_match_q <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                if (round_w || round_l) begin
                    pend_round_q      <= 1'b1;
                    pend_round_code_q <= round_w ? CODE_ROUND_W : CODE_ROUND_L;
                    pend_round_data_q <= COUNTER_SIZE'(round_w ? win_inc : lose_inc);
                end else if (take_round) begin
                    pend_round_q <= 1'b0;
                end
                if (match_hit) pend_match_q <= 1'b1;
                else if (take_match) pend_match_q <= 1'b0;
                if (drop || collision) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_code_q <= 3'd0;
            last_data_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                code_mem[i] <= 3'd0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                code_mem[wr_ptr_q] <= push_code;
                data_mem[wr_ptr_q] <= push_data;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                // Remember the popped head so the outputs hold once empty.
                last_code_q <= code_mem[rd_ptr_q];
                last_data_q <= data_mem[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        evt_code = evt_valid ? code_mem[rd_ptr_q] : last_code_q;
        evt_data = evt_valid ? data_mem[rd_ptr_q] : last_data_q;
    end

`ifdef SCOREBOARD_TIMESTAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            time_q      <= 16'd0;
            last_time_q <= 16'd0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) time_mem[i] <= 16'd0;
        end else begin
            time_q <= time_q + 16'd1;
            if (push_ok) time_mem[wr_ptr_q] <= time_q;
            if (pop) last_time_q <= time_mem[rd_ptr_q];
        end
    end

    assign evt_time = evt_valid ? time_mem[rd_ptr_q] : last_time_q;
`endif

endmodule

// File: tb/tb_game_scoreboard.sv
// Self-checking bench for game_scoreboard: directed vector table, hand-written
// match/overflow/clear/reset sequences and a randomized run, all compared
// against a queue-based reference model of the scoreboard rules.
module tb_game_scoreboard;
    localparam int CS    = 4;
    localparam int MR    = 3;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          WINNER = 1'b0, LOSER = 1'b0, GAMEOVER = 1'b0, clear = 1'b0;
    logic          evt_ready = 1'b0;
    logic [1:0]    WHO = 2'b00;
    logic [CS-1:0] counter_value = '0;
    logic          evt_valid, match_over, overflow;
    logic [2:0]    evt_code;
    logic [CS-1:0] evt_data;
    logic [3:0]    win_rounds, lose_rounds;
    logic [1:0]    match_winner;
`ifdef SCOREBOARD_TIMESTAMP_EN
    logic [15:0]   evt_time;
`endif

    game_scoreboard #(.COUNTER_SIZE(CS), .MATCH_ROUNDS(MR), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .WINNER(WINNER), .LOSER(LOSER),
        .GAMEOVER(GAMEOVER), .WHO(WHO), .counter_value(counter_value), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_data(evt_data),
`ifdef SCOREBOARD_TIMESTAMP_EN
        .evt_time(evt_time),
`endif
        .win_rounds(win_rounds), .lose_rounds(lose_rounds), .match_over(match_over),
        .match_winner(match_winner), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]    code;
        logic [CS-1:0] data;
    } ev_t;

    ev_t        mq[$];
    ev_t        m_last, m_pr_ev;
    int         m_win, m_lose;
    bit         m_over, m_ovf, m_prev_go, m_pr, m_pm;
    logic [1:0] m_winner;

    task automatic model_reset();
        mq.delete();
        m_last = '0; m_pr_ev = '0;
        m_win = 0; m_lose = 0; m_winner = 2'b00;
        m_over = 0; m_ovf = 0; m_prev_go = 0; m_pr = 0; m_pm = 0;
    endtask

    task automatic model_step(input bit w, l, go, input logic [1:0] who,
                              input logic [CS-1:0] cv, input bit clr, rdy);
        bit  pop, have, rise;
        ev_t ev;
        pop  = (mq.size() > 0) && rdy;
        have = 0;
        ev   = '0;
        if (!clr && !m_over && (w || l)) begin
            have = 1; ev.code = l ? 3'd2 : 3'd1; ev.data = cv;
        end else if (!clr && m_pr) begin
            have = 1; ev = m_pr_ev; m_pr = 0;
        end else if (!clr && m_pm) begin
            have = 1; ev.code = 3'd5; ev.data = CS'(m_winner); m_pm = 0;
        end
        if (pop) m_last = mq.pop_front();
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1;
        end
        rise = go && !m_prev_go;
        m_prev_go = go;
        if (clr) begin
            m_win = 0; m_lose = 0; m_over = 0; m_winner = 2'b00;
            m_ovf = 0; m_pr = 0; m_pm = 0;
        end else if (rise && !m_over && (who == 2'b10 || who == 2'b01)) begin
            if (m_pr) m_ovf = 1;
            m_pr = 1;
            if (who == 2'b10) begin
                if (m_win < 15) m_win++;
                m_pr_ev.code = 3'd3; m_pr_ev.data = CS'(m_win);
                if (m_win == MR) begin m_over = 1; m_winner = who; m_pm = 1; end
            end else begin
                if (m_lose < 15) m_lose++;
                m_pr_ev.code = 3'd4; m_pr_ev.data = CS'(m_lose);
                if (m_lose == MR) begin m_over = 1; m_winner = who; m_pm = 1; end
            end
        end
    endtask

    task automatic check_model();
        bit  v;
        ev_t h;
        v = mq.size() > 0;
        h = v ? mq[0] : m_last;
        chk("evt_valid", evt_valid, v);
        chk("evt_code", evt_code, h.code);
        chk("evt_data", evt_data, h.data);
        chk("win_rounds", win_rounds, m_win);
        chk("lose_rounds", lose_rounds, m_lose);
        chk("match_over", match_over, m_over);
        chk("match_winner", match_winner, m_winner);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic cycle(input bit w, l, go, input logic [1:0] who,
                         input logic [CS-1:0] cv, input bit clr, rdy);
        WINNER = w; LOSER = l; GAMEOVER = go; WHO = who;
        counter_value = cv; clear = clr; evt_ready = rdy;
        model_step(w, l, go, who, cv, clr, rdy);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 2'b00, '0, 0, rdy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " evt_valid"}, evt_valid, 0);
        chk({tag, " evt_code"}, evt_code, 0);
        chk({tag, " evt_data"}, evt_data, 0);
        chk({tag, " win_rounds"}, win_rounds, 0);
        chk({tag, " lose_rounds"}, lose_rounds, 0);
        chk({tag, " match_over"}, match_over, 0);
        chk({tag, " match_winner"}, match_winner, 0);
        chk({tag, " overflow"}, overflow, 0);
    endtask

    typedef struct {
        bit            w, l, go;
        logic [1:0]    who;
        logic [CS-1:0] cv;
        bit            rdy;
        bit            ev;
        logic [2:0]    ec;
        logic [CS-1:0] ed;
        int            ew, el;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic go_r;
        tbl[0]  = '{1, 0, 0, 2'b00, 15, 1, 1, 3'd1, 15, 0, 0};
        tbl[1]  = '{0, 0, 0, 2'b00, 0,  1, 0, 3'd1, 15, 0, 0};
        tbl[2]  = '{0, 1, 1, 2'b01, 0,  0, 1, 3'd2, 0,  0, 1};
        tbl[3]  = '{0, 0, 1, 2'b01, 0,  0, 1, 3'd2, 0,  0, 1};
        tbl[4]  = '{0, 0, 0, 2'b00, 0,  1, 1, 3'd4, 1,  0, 1};
        tbl[5]  = '{0, 0, 0, 2'b00, 0,  1, 0, 3'd4, 1,  0, 1};
        tbl[6]  = '{0, 0, 1, 2'b10, 0,  1, 0, 3'd4, 1,  1, 1};
        tbl[7]  = '{0, 0, 0, 2'b00, 0,  0, 1, 3'd3, 1,  1, 1};
        tbl[8]  = '{0, 0, 1, 2'b11, 0,  1, 0, 3'd3, 1,  1, 1};
        tbl[9]  = '{0, 0, 0, 2'b00, 0,  1, 0, 3'd3, 1,  1, 1};
        tbl[10] = '{0, 0, 1, 2'b00, 0,  1, 0, 3'd3, 1,  1, 1};

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        // Directed vectors: first-word fall-through, order, hold-when-empty.
        foreach (tbl[i]) begin
            cycle(tbl[i].w, tbl[i].l, tbl[i].go, tbl[i].who, tbl[i].cv, 0, tbl[i].rdy);
            chk($sformatf("vec%0d evt_valid", i), evt_valid, tbl[i].ev);
            chk($sformatf("vec%0d evt_code", i), evt_code, tbl[i].ec);
            chk($sformatf("vec%0d evt_data", i), evt_data, tbl[i].ed);
            chk($sformatf("vec%0d win_rounds", i), win_rounds, tbl[i].ew);
            chk($sformatf("vec%0d lose_rounds", i), lose_rounds, tbl[i].el);
        end

        // Match won by the winner side, then events are ignored.
        cycle(0, 0, 0, 2'b00, '0, 1, 1);
        chk("clear win_rounds", win_rounds, 0);
        for (int r = 1; r <= MR; r++) begin
            cycle(0, 0, 1, 2'b10, '0, 0, 1);
            chk("match win_rounds", win_rounds, r);
            if (r == MR) begin
                chk("match_over set", match_over, 1);
                chk("match_winner", match_winner, 2);
            end
            idle(1);
            chk("round_w code", evt_code, 3);
            chk("round_w data", evt_data, r);
            idle(1);
            if (r == MR) begin
                chk("match code", evt_code, 5);
                chk("match data", evt_data, 2);
                chk("match valid", evt_valid, 1);
                idle(1);
            end
        end
        cycle(1, 0, 0, 2'b00, 7, 0, 1);
        chk("ignored pulse valid", evt_valid, 0);
        cycle(0, 0, 1, 2'b10, '0, 0, 1);
        chk("ignored round", win_rounds, MR);

        // Overflow on a full FIFO, then push accepted alongside a pop.
        cycle(0, 0, 0, 2'b00, '0, 1, 0);
        chk("clear match_over", match_over, 0);
        for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 2'b00, CS'(i), 0, 0);
        chk("full overflow", overflow, 1);
        chk("full head", evt_data, 1);
        cycle(1, 0, 0, 2'b00, 6, 0, 1);
        chk("push with pop head", evt_data, 2);
        idle(1); chk("drain a", evt_data, 3);
        idle(1); chk("drain b", evt_data, 4);
        idle(1); chk("drain c", evt_data, 6);
        idle(1); chk("drain empty", evt_valid, 0);

        // Loser side takes the match; clear in match end keeps the FIFO.
        for (int r = 1; r <= MR; r++) begin
            cycle(0, 0, 1, 2'b01, '0, 0, 0);
            idle(0);
            idle(0);
        end
        chk("lose match_winner", match_winner, 1);
        cycle(0, 0, 0, 2'b00, '0, 1, 0);
        chk("clr lose_rounds", lose_rounds, 0);
        chk("clr overflow", overflow, 0);
        chk("clr match_winner", match_winner, 0);
        chk("clr kept valid", evt_valid, 1);
        chk("clr kept code", evt_code, 4);
        repeat (4) idle(1);
        cycle(1, 0, 0, 2'b00, 9, 0, 1);
        chk("post-clear win code", evt_code, 1);
        chk("post-clear win data", evt_data, 9);
        idle(1);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 2'b00, CS'(10 + i), 0, 0);
        idle(1);
        chk("pre-reset valid", evt_valid, 1);
        reset_n = 1'b0;
        #1;
        check_zero("async reset");
        model_reset();
        @(posedge clock);
        #4;
        reset_n = 1'b1;
        idle(1);
        chk("post-reset empty", evt_valid, 0);

        // Randomized traffic.
        go_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) go_r = ~go_r;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, go_r,
                  2'($urandom_range(0, 3)), CS'($urandom), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
